branch_predictor: RTL
=====================

# branch_predictor

Parametrised branch prediction unit for the pipelined RV32I core, replacing the inline gshare table and history register in decode/execute. Provides a combinational taken/not-taken prediction and table index to decode, and accepts resolved outcomes from execute. Adds three things the inline predictor lacks:
- self-initialising pattern table;
- selectable bimodal/gshare indexing;
- return address stack (RAS) for JAL/JALR call/return pairs, plus hit/branch performance counters.

## Interface
Parameters:
- BHT_ADDR_BITS, 12, log2 of pattern-table entries (2-bit saturating counters); legal 2..21.
- HIST_BITS, 8, global history length; must be ≤ BHT_ADDR_BITS.
- MODE, 1, indexing mode: 0 = bimodal, 1 = gshare.
- RAS_DEPTH, 8, return stack entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- ready  out  1  high once table initialisation is complete.
- pd_valid  in  1  decode-stage instruction valid (not flushed).
- pd_pc  in  32  decode-stage PC.
- pd_isB  in  1  decode instruction is a conditional branch.
- pd_isCall  in  1  JAL/JALR with rd = x1 or x5.
- pd_isRet  in  1  JALR with rs1 = x1 or x5, rd = x0.
- pd_taken  out  1  predicted direction.
- pd_index  out  BHT_ADDR_BITS  table index, carried down the pipe with the branch.
- pd_ret_addr  out  32  RAS top entry.
- pd_ret_valid  out  1  RAS non-empty and pd_isRet.
- rs_valid  in  1  execute-stage resolved conditional branch.
- rs_index  in  BHT_ADDR_BITS  index captured at predict time.
- rs_taken  in  1  actual outcome.
- rs_pred  in  1  prediction that was used.
- nb_branch  out  32  resolved branch count.
- nb_hit  out  32  correctly predicted count.

## Operation

**State machine: INIT → RUN.**
- Any cycle with resetn = 0 forces INIT with init pointer = 0, ready = 0.
- In INIT, each cycle with resetn = 1 writes entry[ptr] = 2'b01 (weakly not-taken) and increments ptr.
- After the write to entry 2^BHT_ADDR_BITS−1, move to RUN and assert ready.

**In INIT:**
- pd_taken = 0 and pd_ret_valid = 0.
- RAS push/pop and rs_valid are ignored.
- GHR and counters are held at 0.

**Index:**
- MODE 0: pd_index = pd_pc[BHT_ADDR_BITS+1:2].
- MODE 1: pd_index = pd_pc[BHT_ADDR_BITS+1:2] XOR (GHR << (BHT_ADDR_BITS−HIST_BITS)).

**Prediction:**
- pd_taken = ready & pd_isB & BHT[pd_index][1].
- Combinational from pd_pc and the current GHR; pd_valid is not needed for the lookup.

**Update (RUN, rs_valid = 1):**
- BHT[rs_index] saturating increment if rs_taken, else decrement (00 and 11 saturate).
- GHR ← {rs_taken, GHR[HIST_BITS−1:1]}; newest outcome in the MSB.
- nb_branch += 1.
- nb_hit += 1 when rs_taken == rs_pred.
- Counters wrap modulo 2^32.

**RAS (RUN, pd_valid = 1):**
- Circular buffer with top pointer and occupancy count 0..RAS_DEPTH.
- Call: push pd_pc+4.
- Ret with count > 0: pop.
- Ret with count 0: no change; pd_ret_valid = 0.
- Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
- Call and Ret in the same cycle: pop then push, so the top entry is replaced by pd_pc+4 and count is unchanged (count 0 → 1).

## Timing
- Prediction outputs are combinational, same cycle as pd_pc.
- BHT, GHR and RAS updates take effect at the clock edge. The first visibility to pd_* lookups is the next cycle.
- Same-cycle rs update and pd lookup at the same index: the lookup returns the pre-update value (read-before-write).
- Initialisation latency: ready rises on the edge after 2^BHT_ADDR_BITS consecutive resetn-high cycles.
- Reset asserted mid-operation (INIT or RUN), on the next edge:
  - returns to INIT and restarts initialisation from 0;
  - clears GHR, RAS count/pointer, nb_branch and nb_hit.
- Reset values of outputs:
  - ready, pd_taken, pd_ret_valid, nb_branch, nb_hit: 0.
  - pd_index follows pd_pc with GHR = 0.
  - pd_ret_addr is don't-care while count = 0.

## Test plan
Use BHT_ADDR_BITS=4, HIST_BITS=2, RAS_DEPTH=4 unless stated.

1. **Init:** hold resetn low 3 cycles, then high.
   - ready = 0 for 16 cycles, then 1.
   - Every index predicts not-taken; pd_taken = 0 even with pd_isB = 1 during INIT.
2. **Saturation:** MODE 0, pd_pc = 0x40 gives index 0.
   - Resolve taken 3× at index 0: pd_taken becomes 1 after the 1st resolve; counter is 11 after the 2nd and stays 11.
   - Then 2 not-taken resolves: pd_taken = 0.
3. **gshare:** MODE 1, resolve taken then not-taken.
   - GHR = 2'b01 → pd_pc = 0x40 yields pd_index = 4'b0100.
   - Same-cycle update/lookup at that index returns the old counter.
4. **RAS:** 5 calls at PCs 0x100, 0x200, 0x300, 0x400, 0x500.
   - Pops return 0x504, 0x404, 0x304, 0x204.
   - 5th pop gives pd_ret_valid = 0.
   - Simultaneous call+ret at 0x600 with one entry present leaves top = 0x604, count unchanged.
5. **Counters:** 10 resolves with rs_pred == rs_taken on 7 → nb_branch = 10, nb_hit = 7.
6. **Mid-operation reset:** assert resetn low in RUN.
   - Counters, GHR and RAS are cleared.
   - ready = 0 and the full 16-cycle re-init occurs; a previously trained index predicts not-taken.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch prediction unit: 2-bit saturating pattern table with bimodal or gshare
// indexing, global history register, return address stack and hit counters.
// The pattern table initialises itself to weakly-not-taken after reset.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   ready              table initialisation complete
//   pd_*               decode-side lookup: pc/type in, prediction/index/RAS top out
//   rs_*               execute-side resolution of a conditional branch
//   nb_branch, nb_hit  resolved-branch and correct-prediction counters
module branch_predictor #(
  parameter int unsigned BHT_ADDR_BITS = 12,
  parameter int unsigned HIST_BITS     = 8,
  parameter int unsigned MODE          = 1,
  parameter int unsigned RAS_DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     ready,
  input  logic                     pd_valid,
  input  logic [31:0]              pd_pc,
  input  logic                     pd_isB,
  input  logic                     pd_isCall,
  input  logic                     pd_isRet,
  output logic                     pd_taken,
  output logic [BHT_ADDR_BITS-1:0] pd_index,
  output logic [31:0]              pd_ret_addr,
  output logic                     pd_ret_valid,
  input  logic                     rs_valid,
  input  logic [BHT_ADDR_BITS-1:0] rs_index,
  input  logic                     rs_taken,
  input  logic                     rs_pred,
  output logic [31:0]              nb_branch,
  output logic [31:0]              nb_hit
);

  localparam int unsigned BhtDepth = 2 ** BHT_ADDR_BITS;
  localparam int unsigned RasPtrW  = $clog2(RAS_DEPTH);
  localparam int unsigned RasCntW  = $clog2(RAS_DEPTH + 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e                   state_q, state_d;
  logic [BHT_ADDR_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [1:0]               bht_q [BhtDepth];
  logic                     bht_we;
  logic [BHT_ADDR_BITS-1:0] bht_waddr;
  logic [1:0]               bht_wdata;
  logic [1:0]               rs_cnt;
  logic [HIST_BITS-1:0]     ghr_q, ghr_d;
  logic [31:0]              nb_branch_q, nb_branch_d;
  logic [31:0]              nb_hit_q, nb_hit_d;

  logic [31:0]              ras_q [RAS_DEPTH];
  logic [RasPtrW-1:0]       top_q, top_d, top_pop;
  logic [RasCntW-1:0]       cnt_q, cnt_d, cnt_pop;
  logic                     ras_push, ras_pop;

  logic [BHT_ADDR_BITS-1:0] pc_idx, hist_idx;

  assign ready = (state_q == StRun);

  // History is left-aligned so the newest outcome perturbs the top index bit.
  assign pc_idx   = pd_pc[BHT_ADDR_BITS+1:2];
  assign hist_idx = BHT_ADDR_BITS'(ghr_q) << (BHT_ADDR_BITS - HIST_BITS);
  assign pd_index = (MODE == 0) ? pc_idx : (pc_idx ^ hist_idx);

  // Table read is combinational on the pre-edge contents: read-before-write.
  assign pd_taken = ready & pd_isB & bht_q[pd_index][1];

  assign pd_ret_addr  = ras_q[top_q];
  assign pd_ret_valid = ready & pd_isRet & (cnt_q != '0);

  assign nb_branch = nb_branch_q;
  assign nb_hit    = nb_hit_q;

  assign rs_cnt = bht_q[rs_index];

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    bht_we      = 1'b0;
    bht_waddr   = init_ptr_q;
    bht_wdata   = 2'b01;
    ghr_d       = ghr_q;
    nb_branch_d = nb_branch_q;
    nb_hit_d    = nb_hit_q;
    unique case (state_q)
      StInit: begin
        bht_we     = 1'b1;
        init_ptr_d = init_ptr_q + BHT_ADDR_BITS'(1);
        if (init_ptr_q == '1) state_d = StRun;
      end
      StRun: begin
        if (rs_valid) begin
          bht_we    = 1'b1;
          bht_waddr = rs_index;
          if (rs_taken) bht_wdata = (rs_cnt == 2'b11) ? 2'b11 : rs_cnt + 2'b01;
          else          bht_wdata = (rs_cnt == 2'b00) ? 2'b00 : rs_cnt - 2'b01;
          ghr_d       = (ghr_q >> 1) | (HIST_BITS'(rs_taken) << (HIST_BITS - 1));
          nb_branch_d = nb_branch_q + 32'd1;
          if (rs_taken == rs_pred) nb_hit_d = nb_hit_q + 32'd1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Pop then push: a simultaneous call/return replaces the top entry in place.
  always_comb begin
    ras_pop  = ready & pd_valid & pd_isRet & (cnt_q != '0);
    ras_push = ready & pd_valid & pd_isCall;
    top_pop  = ras_pop ? top_q - RasPtrW'(1) : top_q;
    cnt_pop  = ras_pop ? cnt_q - RasCntW'(1) : cnt_q;
    top_d    = ras_push ? top_pop + RasPtrW'(1) : top_pop;
    cnt_d    = cnt_pop;
    // A full stack overwrites its oldest slot, so occupancy saturates.
    if (ras_push && (cnt_pop != RasCntW'(RAS_DEPTH))) cnt_d = cnt_pop + RasCntW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StInit;
      init_ptr_q  <= '0;
      ghr_q       <= '0;
      top_q       <= '0;
      cnt_q       <= '0;
      nb_branch_q <= '0;
      nb_hit_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      ghr_q       <= ghr_d;
      top_q       <= top_d;
      cnt_q       <= cnt_d;
      nb_branch_q <= nb_branch_d;
      nb_hit_q    <= nb_hit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && bht_we) bht_q[bht_waddr] <= bht_wdata;
  end

  always_ff @(posedge clk) begin
    if (resetn && ras_push) ras_q[top_d] <= pd_pc + 32'd4;
  end

endmodule
